fifo_ctrl: RTL and testbench

Synchronous single-clock FIFO with storage array, read/write pointers, occupancy tracking and status flags. It accepts write/read requests from the producer/consumer and drives increment/decrement strobes that feed the 3-bit occupancy counter block directly downstream. It also keeps its own full-width count, so flags never depend on the 3-bit counter wrapping.

---
 rtl/fifo_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Single-clock synchronous FIFO with storage, read/write
//                pointers, full-width occupancy count, status flags,
//                registered increment/decrement strobes for a downstream
//                occupancy counter, and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              increment,
    output logic              decrement,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_AF      = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] c_AE      = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] c_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              r_increment;
    logic              r_decrement;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Flags decode the registered count; acceptance uses pre-edge flags so a
    // write into an empty FIFO cannot be read back in the same cycle.
    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    // Storage array: written only on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, read data path, strobes and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_increment <= 1'b0;
            r_decrement <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_rd_acc;

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_increment <= w_wr_acc & ~w_rd_acc;
            r_decrement <= w_rd_acc & ~w_wr_acc;
            r_overflow  <= r_overflow  | (wr_en & w_full);
            r_underflow <= r_underflow | (rd_en & w_empty);
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign increment    = r_increment;
    assign decrement    = r_decrement;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Self-checking bench for fifo_ctrl; directed scenarios plus
//                random traffic compared against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    localparam int WIDTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              increment;
    logic              decrement;
    logic              overflow;
    logic              underflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rd_data = '0;
    bit               m_rd_valid, m_inc, m_dec, m_ovf, m_unf;

    fifo_ctrl #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .increment    (increment),
        .decrement    (decrement),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare every output.
    task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit rs);
        bit m_full, m_empty, wa, ra;
        int n;
        reset   = rs;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_rd_data  = '0;
            m_rd_valid = 0;
            m_inc      = 0;
            m_dec      = 0;
            m_ovf      = 0;
            m_unf      = 0;
        end else begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            wa = w && !m_full;
            ra = r && !m_empty;
            if (ra) m_rd_data = q.pop_front();
            if (wa) q.push_back(d);
            m_rd_valid = ra;
            m_inc      = wa && !ra;
            m_dec      = ra && !wa;
            m_ovf      = m_ovf || (w && m_full);
            m_unf      = m_unf || (r && m_empty);
        end
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        chk("rd_data",      32'(rd_data),      32'(m_rd_data));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= AF_LEVEL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
        chk("increment",    32'(increment),    32'(m_inc));
        chk("decrement",    32'(decrement),    32'(m_dec));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
    endtask

    initial begin
        int wp, rp, incs, decs;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

        // Reset state
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);

        // Fill with 0x10..0x17
        incs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(8'h10 + i), 0, 0);
            if (increment) incs++;
        end
        chk("fill_inc_pulses", 32'(incs), 32'd8);

        // Write while full is rejected and flagged
        step(1, 8'hAA, 0, 0);
        step(0, 8'h00, 0, 0);

        // Drain: expect 0x10..0x17
        decs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'h00, 1, 0);
            chk("drain_data", 32'(rd_data), 32'(8'h10 + i));
            if (decrement) decs++;
        end
        chk("drain_dec_pulses", 32'(decs), 32'd8);

        // Simultaneous read/write on empty, then read back
        step(1, 8'h55, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("empty_rw_readback", 32'(rd_data), 32'h55);

        // Pointer wrap
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'h00, 1, 0);
            chk("wrap_data", 32'(rd_data), 32'(8'h20 + i));
        end

        // Steady state at count 4, then reset mid-stream
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h50 + i), 1, 0);
        step(1, 8'h99, 1, 1);
        step(0, 8'h00, 0, 0);

        // Random traffic with varying write/read bias and occasional reset
        wp = 50; rp = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) begin
                wp = 20 + int'($urandom_range(60));
                rp = 20 + int'($urandom_range(60));
            end
            step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
                 $urandom_range(199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
